// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: register enables, bubble clears and stage valid bits.
// Optional CTRL_PERF_CNT_EN adds saturating stall/flush counters; otherwise the perf ports read zero.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 4,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_is_load,
    input  logic                  ex_is_md,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_wait,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_clr,
    output logic                  idex_clr,
    output logic                  exmem_clr,
    output logic                  memwb_clr,
    output logic                  v_id,
    output logic                  v_ex,
    output logic                  v_mem,
    output logic                  v_wb,
    output logic                  md_busy,
    output logic [PERF_W-1:0]     perf_stall_cnt,
    output logic [PERF_W-1:0]     perf_flush_cnt
);

    localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] MD_INIT = CNT_W'((MD_LATENCY > 1) ? MD_LATENCY - 2 : 0);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_done_q, md_done_d;
    logic             v_id_q, v_id_d, v_ex_q, v_ex_d, v_mem_q, v_mem_d, v_wb_q, v_wb_d;
    logic             load_use, branch_flush, md_start;

    assign load_use = v_ex_q && ex_is_load && (ex_rd != '0) && v_id_q &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign branch_flush = v_ex_q && ex_branch_taken;
    // The op whose latency just expired is leaving EX and must not restart the wait.
    assign md_start = v_ex_q && ex_is_md && (MD_LATENCY > 1) && !md_done_q;

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        exmem_en  = 1'b0;
        memwb_en  = 1'b0;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        memwb_clr = 1'b0;
        if (!reset) begin
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
            memwb_clr = 1'b1;
        end else if (dmem_wait) begin
            // whole pipe frozen
        end else if (state_q == MD_WAIT) begin
            exmem_en  = 1'b1;
            exmem_clr = 1'b1;
            memwb_en  = 1'b1;
        end else if (branch_flush) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (load_use) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            idex_clr = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_done_d = md_done_q;
        if (!dmem_wait) begin
            md_done_d = 1'b0;
            if (state_q == MD_WAIT) begin
                if (md_cnt_q == '0) begin
                    state_d   = RUN;
                    md_done_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                end
            end else if (md_start) begin
                state_d  = MD_WAIT;
                md_cnt_d = MD_INIT;
            end
        end
        // Clear beats enable beats hold; each stage inherits its upstream valid.
        v_id_d  = ifid_clr  ? 1'b0 : (ifid_en  ? if_valid : v_id_q);
        v_ex_d  = idex_clr  ? 1'b0 : (idex_en  ? v_id_q   : v_ex_q);
        v_mem_d = exmem_clr ? 1'b0 : (exmem_en ? v_ex_q   : v_mem_q);
        v_wb_d  = memwb_clr ? 1'b0 : (memwb_en ? v_mem_q  : v_wb_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            md_cnt_q  <= '0;
            md_done_q <= 1'b0;
            v_id_q    <= 1'b0;
            v_ex_q    <= 1'b0;
            v_mem_q   <= 1'b0;
            v_wb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
            v_id_q    <= v_id_d;
            v_ex_q    <= v_ex_d;
            v_mem_q   <= v_mem_d;
            v_wb_q    <= v_wb_d;
        end
    end

    assign v_id    = v_id_q;
    assign v_ex    = v_ex_q;
    assign v_mem   = v_mem_q;
    assign v_wb    = v_wb_q;
    assign md_busy = (state_q == MD_WAIT);

`ifdef CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic              flush_fire;

    assign flush_fire = !dmem_wait && (state_q == RUN) && branch_flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
        if (flush_fire && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = {PERF_W{1'b0}};
    assign perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus random stimulus for pipe_hazard_ctrl, checked against a cycle-level
// behavioural model that counts remaining stall cycles instead of tracking FSM states.
module tb_pipe_hazard_ctrl;

    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int PW     = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_valid;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_is_load, ex_is_md, ex_branch_taken, dmem_wait;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic          v_id, v_ex, v_mem, v_wb, md_busy;
    logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit            mv[4];
    int            md_left  = 0;
    bit            md_guard = 0;
    logic [PW-1:0] m_stall  = '0;
    logic [PW-1:0] m_flush  = '0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .MD_LATENCY(MD_LAT), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_is_load(ex_is_load), .ex_is_md(ex_is_md), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .dmem_wait(dmem_wait),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
        .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb), .md_busy(md_busy),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: check combinational outputs against the model, clock, advance the model, check state.
    task automatic cycle();
        logic [4:0] e_en;   // {pc, ifid, idex, exmem, memwb}
        logic [3:0] e_clr;  // {ifid, idex, exmem, memwb}
        bit         lu, fl;
        bit         ov[4];
        int         old_left;
        #2;
        lu = ex_is_load && (ex_rd != 0) && mv[1] && mv[0] &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        fl = mv[1] && ex_branch_taken;
        if (!reset)           begin e_en = 5'b00000; e_clr = 4'b1111; end
        else if (dmem_wait)   begin e_en = 5'b00000; e_clr = 4'b0000; end
        else if (md_left > 0) begin e_en = 5'b00011; e_clr = 4'b0010; end
        else if (fl)          begin e_en = 5'b11111; e_clr = 4'b1100; end
        else if (lu)          begin e_en = 5'b00111; e_clr = 4'b0100; end
        else                  begin e_en = 5'b11111; e_clr = 4'b0000; end
        check("pc_en",     pc_en,     e_en[4]);
        check("ifid_en",   ifid_en,   e_en[3]);
        check("idex_en",   idex_en,   e_en[2]);
        check("exmem_en",  exmem_en,  e_en[1]);
        check("memwb_en",  memwb_en,  e_en[0]);
        check("ifid_clr",  ifid_clr,  e_clr[3]);
        check("idex_clr",  idex_clr,  e_clr[2]);
        check("exmem_clr", exmem_clr, e_clr[1]);
        check("memwb_clr", memwb_clr, e_clr[0]);
        @(posedge clk);
        #1;
        ov = mv;
        old_left = md_left;
        mv[0] = e_clr[3] ? 1'b0 : (e_en[3] ? if_valid : ov[0]);
        mv[1] = e_clr[2] ? 1'b0 : (e_en[2] ? ov[0]    : ov[1]);
        mv[2] = e_clr[1] ? 1'b0 : (e_en[1] ? ov[1]    : ov[2]);
        mv[3] = e_clr[0] ? 1'b0 : (e_en[0] ? ov[2]    : ov[3]);
        if (!reset) begin
            md_left  = 0;
            md_guard = 0;
        end else if (!dmem_wait) begin
            if (md_left > 0) begin
                md_left--;
                md_guard = (md_left == 0);
            end else begin
                if (ov[1] && ex_is_md && MD_LAT > 1 && !md_guard) md_left = MD_LAT - 1;
                md_guard = 0;
            end
        end
`ifdef CTRL_PERF_CNT_EN
        if (!reset) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!e_en[4] && m_stall != '1) m_stall++;
            if (!dmem_wait && old_left == 0 && fl && m_flush != '1) m_flush++;
        end
`else
        old_left = old_left;
`endif
        check("v_id",    v_id,    mv[0]);
        check("v_ex",    v_ex,    mv[1]);
        check("v_mem",   v_mem,   mv[2]);
        check("v_wb",    v_wb,    mv[3]);
        check("md_busy", md_busy, md_left > 0);
        check("perf_stall", perf_stall_cnt, m_stall);
        check("perf_flush", perf_flush_cnt, m_flush);
    endtask

    initial begin
        int busy, bub;
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        reset = 1'b0; if_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0; ex_is_md = 1'b0;
        ex_branch_taken = 1'b0; dmem_wait = 1'b0;
        @(posedge clk);
        #1;

        // Reset held three cycles, then release with a steady instruction stream
        for (int i = 0; i < 3; i++) begin
            check("rst_idex_clr", idex_clr, 1'b1);
            check("rst_pc_en", pc_en, 1'b0);
            cycle();
        end
        reset = 1'b1; if_valid = 1'b1;
        cycle();
        check("rel_v_id_1", v_id, 1'b1);
        check("rel_v_wb_1", v_wb, 1'b0);
        cycle(); cycle(); cycle();
        check("rel_v_wb_4", v_wb, 1'b1);

        // Load-use on rs2=5: exactly one stall cycle
        ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        #1;
        check("lu_pc_en", pc_en, 1'b0);
        check("lu_ifid_en", ifid_en, 1'b0);
        check("lu_idex_clr", idex_clr, 1'b1);
        cycle();
        check("lu_v_ex", v_ex, 1'b0);
        check("lu_once_pc_en", pc_en, 1'b1);
        cycle();
        // Same shape with x0 as destination: no hazard
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        check("x0_pc_en", pc_en, 1'b1);
        check("x0_idex_clr", idex_clr, 1'b0);
        cycle();

        // Taken branch coincident with load-use: flush wins
        ex_rd = 5'd5; id_rs2 = 5'd5; ex_branch_taken = 1'b1;
        #1;
        check("br_pc_en", pc_en, 1'b1);
        check("br_ifid_clr", ifid_clr, 1'b1);
        check("br_idex_clr", idex_clr, 1'b1);
        cycle();
        check("br_v_id", v_id, 1'b0);
        check("br_v_ex", v_ex, 1'b0);
        ex_branch_taken = 1'b0; ex_is_load = 1'b0; id_use_rs2 = 1'b0; ex_rd = '0; id_rs2 = '0;
        cycle(); cycle();

        // Mul/div with no memory wait: three busy cycles, three MEM bubbles
        ex_is_md = 1'b1;
        cycle();
        ex_is_md = 1'b0;
        busy = 0; bub = 0;
        for (int i = 0; i < 6; i++) begin
            if (md_busy) busy++;
            if (exmem_en && exmem_clr) bub++;
            cycle();
        end
        check("md_busy_cycles", busy, 3);
        check("md_bubbles", bub, 3);
        check("md_after_idex_en", idex_en, 1'b1);

        // Mul/div with a two-cycle memory wait inside MD_WAIT: busy stretches by two
        ex_is_md = 1'b1;
        cycle();
        ex_is_md = 1'b0;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            dmem_wait = (i == 1 || i == 2);
            if (md_busy) busy++;
            if (i == 1) begin
                #1;
                check("dw_exmem_en", exmem_en, 1'b0);
                check("dw_memwb_en", memwb_en, 1'b0);
                check("dw_exmem_clr", exmem_clr, 1'b0);
            end
            cycle();
        end
        dmem_wait = 1'b0;
        check("md_wait_busy_cycles", busy, 5);

        // Reset asserted mid MD_WAIT aborts to RUN with an empty pipe
        ex_is_md = 1'b1;
        cycle();
        ex_is_md = 1'b0;
        check("abort_busy_before", md_busy, 1'b1);
        cycle();
        reset = 1'b0;
        cycle();
        check("abort_md_busy", md_busy, 1'b0);
        check("abort_v_ex", v_ex, 1'b0);
        check("abort_v_wb", v_wb, 1'b0);
        reset = 1'b1;

        // Random traffic with small register indices so hazards and x0 occur often
        for (int n = 0; n < 600; n++) begin
            reset           = ($urandom_range(0, 39) != 0);
            if_valid        = ($urandom_range(0, 3) != 0);
            dmem_wait       = ($urandom_range(0, 5) == 0);
            ex_is_md        = ($urandom_range(0, 9) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_is_load      = ($urandom_range(0, 3) == 0);
            id_use_rs1      = $urandom_range(0, 1);
            id_use_rs2      = $urandom_range(0, 1);
            id_rs1          = AW'($urandom_range(0, 3));
            id_rs2          = AW'($urandom_range(0, 3));
            ex_rd           = AW'($urandom_range(0, 3));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives enable and synchronous clear for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch flushes, data-memory wait stalls and multicycle mul/div occupancy of EX.
- Tracks a valid bit per stage so bubbles are explicit.

Parameters:
REG_ADDR_W, 5, register index width
MD_LATENCY, 4, cycles a mul/div op occupies EX (>=1); MD_LATENCY-1 stall cycles
PERF_W, 32, perf counter width (used only with the optional feature)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-low (0 = reset asserted)
if_valid  in  1  IMEM returned a valid instruction this cycle
id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_is_load  in  1  EX instruction is a load
ex_is_md  in  1  EX instruction is mul/div
ex_rd  in  REG_ADDR_W  destination of EX instruction
ex_branch_taken  in  1  EX resolved taken branch/jump
dmem_wait  in  1  data memory not ready, MEM must hold
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  sync clear (bubble insert)
v_id, v_ex, v_mem, v_wb  out  1 each  stage valid bits
md_busy  out  1  high while in MD_WAIT
perf_stall_cnt  out  PERF_W  stall cycles (optional feature)
perf_flush_cnt  out  PERF_W  flush events (optional feature)

Behaviour:
- Reset (reset=0 at posedge): state=RUN, md_cnt=0, all v_*=0. While reset=0, all *_en=0 and all *_clr=1 (combinational). md_busy=0; perf counters=0.
- FSM states: RUN, MD_WAIT. Enables and clears are combinational from state and inputs; v_* and md_cnt are registered.
- Priority, highest first: dmem_wait > MD_WAIT > branch flush > load-use > normal.
- dmem_wait=1: all *_en=0, all *_clr=0; entire pipe frozen, including the FSM and md_cnt. Pending branch/load-use conditions are evaluated once dmem_wait drops.
- MD entry: RUN with v_ex & ex_is_md & MD_LATENCY>1 -> MD_WAIT, md_cnt=MD_LATENCY-2.
- In MD_WAIT: pc_en, ifid_en, idex_en=0. exmem_en=1 with exmem_clr=1 (bubble into MEM). memwb advances. md_cnt decrements; at md_cnt==0 return to RUN the next cycle, where EX advances normally. Total EX occupancy is MD_LATENCY cycles.
- Branch flush (v_ex & ex_branch_taken): pc_en=1, ifid_clr=1, idex_clr=1; exmem/memwb advance. Flush beats a simultaneous load-use.
- Load-use: v_ex & ex_is_load & ex_rd!=0 & v_id & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Response: pc_en=0, ifid_en=0, idex_clr=1. Exactly 1 stall cycle.
- Normal: all *_en=1, all *_clr=0.
- Valid update, per stage: clr -> 0; else en -> upstream valid (v_id takes if_valid); else hold.
- x0 is never a hazard source.
- reset=0 mid-MD or mid-stall aborts to RUN with all v_*=0.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: perf_stall_cnt increments on every cycle with pc_en=0 while reset=1. perf_flush_cnt increments on each branch-flush cycle. Both saturate at all-ones and clear on reset.
- Undefined: both ports remain and are tied to 0; no counter logic is instantiated.

Test Plan:
- Reset held 3 cycles, then release with if_valid=1 -> all *_clr=1 during reset; v_id=1 one cycle after release, and v_wb=1 four cycles after release.
- Load in EX with ex_rd=5, ID reads rs2=5 -> one cycle of pc_en=0, ifid_en=0, idex_clr=1; v_ex=0 next cycle; the same case with ex_rd=0 -> no stall.
- Taken branch in EX coincident with load-use -> ifid_clr=1, idex_clr=1, pc_en=1; v_id=v_ex=0 next cycle; perf_flush_cnt +1 when the macro is defined.
- ex_is_md with MD_LATENCY=4 -> md_busy high exactly 3 cycles, 3 bubbles reach MEM, then EX advances.
- dmem_wait=1 for 2 cycles during MD_WAIT -> all enables 0, md_cnt frozen; MD completes 2 cycles later than with no wait.
- reset=0 asserted during MD_WAIT -> next cycle state=RUN, md_busy=0, all v_*=0.
